transmit_os: RTL and testbench

PCS transmit ordered-set state machine for a 1000BASE-X (IEEE 802.3 Clause 36 style) transmitter. It sits between the GMII transmit interface and the PCS code-group generator. From `xmit`, `TX_EN` and `TX_OSET_indicate` it decides which ordered set is sent next: /C/, /I/, /S/, /D/, /T/ or /R/. It reports packet activity on `transmitting` and raises collision on `COL`.

---
 rtl/transmit_os_if.sv | 24 ++
 rtl/transmit_os.sv | 182 ++++++++++++++++++
 tb/tb_transmit_os.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/transmit_os_if.sv
// GMII-side and code-group-generator-side signals of the PCS transmit
// ordered-set machine. The master drives the inputs and the slave is the PCS block.
interface transmit_os_if;
    logic       TX_EN;
    logic [7:0] TXD;
    logic       receiving;
    logic       TX_OSET_indicate;
    logic       tx_even;
    logic [2:0] xmit;
    logic       transmitting;
    logic       COL;
    logic [2:0] tx_o_set;
    logic [7:0] tx_data;

    modport master (
        output TX_EN, TXD, receiving, TX_OSET_indicate, tx_even, xmit,
        input  transmitting, COL, tx_o_set, tx_data
    );

    modport slave (
        input  TX_EN, TXD, receiving, TX_OSET_indicate, tx_even, xmit,
        output transmitting, COL, tx_o_set, tx_data
    );
endinterface

// File: rtl/transmit_os.sv
// 1000BASE-X PCS transmit ordered-set state machine. It selects /C/ /I/ /S/ /D/ /T/ /R/
// from xmit, TX_EN and TX_OSET_indicate, and it reports transmitting and COL.
module transmit_os #(
    parameter logic [2:0] XMIT_CONFIG = 3'b001,
    parameter logic [2:0] XMIT_DATA   = 3'b010,
    parameter logic [2:0] XMIT_IDLE   = 3'b100
) (
    input  logic          GTX_CLK,
    input  logic          mr_main_reset,
    transmit_os_if.slave  bus
);

    localparam logic [2:0] OS_D = 3'd0;
    localparam logic [2:0] OS_I = 3'd1;
    localparam logic [2:0] OS_C = 3'd2;
    localparam logic [2:0] OS_S = 3'd3;
    localparam logic [2:0] OS_T = 3'd4;
    localparam logic [2:0] OS_R = 3'd5;

    typedef enum logic [3:0] {
        ST_TX_TEST_XMIT    = 4'd0,
        ST_CONFIGURATION   = 4'd1,
        ST_IDLE            = 4'd2,
        ST_XMIT_DATA       = 4'd3,
        ST_START_OF_PACKET = 4'd4,
        ST_TX_PACKET       = 4'd5,
        ST_END_OF_PACKET   = 4'd6,
        ST_EPD2            = 4'd7,
        ST_EPD3            = 4'd8
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [2:0] xmit_latched_r;
    logic [2:0] xmit_norm_s;
    logic       xmit_change_s;
    logic       transmitting_r;
    logic       col_r;
    logic [2:0] tx_o_set_r;
    logic [7:0] tx_data_r;

    // Ordered set that each state sends.
    function automatic logic [2:0] oset_of(input state_t st);
        case (st)
            ST_CONFIGURATION:   oset_of = OS_C;
            ST_START_OF_PACKET: oset_of = OS_S;
            ST_TX_PACKET:       oset_of = OS_D;
            ST_END_OF_PACKET:   oset_of = OS_T;
            ST_EPD2:            oset_of = OS_R;
            ST_EPD3:            oset_of = OS_R;
            default:            oset_of = OS_I;
        endcase
    endfunction

    // The machine treats any xmit code other than CONFIG or DATA as IDLE.
    always_comb begin
        case (bus.xmit)
            XMIT_CONFIG: xmit_norm_s = XMIT_CONFIG;
            XMIT_DATA:   xmit_norm_s = XMIT_DATA;
            default:     xmit_norm_s = XMIT_IDLE;
        endcase
    end

    // A mode change counts only at an ordered-set boundary. The latched value is taken in TX_TEST_XMIT.
    always_comb begin
        xmit_change_s = (xmit_norm_s != xmit_latched_r) && bus.TX_OSET_indicate;
    end

    // Next-state selection. Inside a packet (/S/ and /D/) the machine ignores mode changes.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_TX_TEST_XMIT: begin
                if (xmit_norm_s == XMIT_CONFIG) begin
                    next_state_s = ST_CONFIGURATION;
                end else if (xmit_norm_s == XMIT_IDLE) begin
                    next_state_s = ST_IDLE;
                end else if (bus.TX_EN) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_XMIT_DATA;
                end
            end
            ST_CONFIGURATION: begin
                if (bus.TX_OSET_indicate && (xmit_norm_s != XMIT_CONFIG)) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else begin
                    next_state_s = ST_CONFIGURATION;
                end
            end
            ST_IDLE: begin
                if (xmit_change_s) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else if (bus.TX_OSET_indicate && (xmit_norm_s == XMIT_CONFIG)) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else if (bus.TX_OSET_indicate && (xmit_norm_s == XMIT_DATA) && !bus.TX_EN) begin
                    next_state_s = ST_XMIT_DATA;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_XMIT_DATA: begin
                if (xmit_change_s) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else if (bus.TX_OSET_indicate && bus.TX_EN) begin
                    next_state_s = ST_START_OF_PACKET;
                end else begin
                    next_state_s = ST_XMIT_DATA;
                end
            end
            ST_START_OF_PACKET, ST_TX_PACKET: begin
                if (!bus.TX_OSET_indicate) begin
                    next_state_s = state_r;
                end else if (bus.TX_EN) begin
                    next_state_s = ST_TX_PACKET;
                end else begin
                    next_state_s = ST_END_OF_PACKET;
                end
            end
            ST_END_OF_PACKET: begin
                if (xmit_change_s) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else if (bus.TX_OSET_indicate) begin
                    next_state_s = ST_EPD2;
                end else begin
                    next_state_s = ST_END_OF_PACKET;
                end
            end
            ST_EPD2: begin
                if (xmit_change_s) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else if (bus.TX_OSET_indicate && bus.tx_even) begin
                    next_state_s = ST_XMIT_DATA;
                end else if (bus.TX_OSET_indicate) begin
                    next_state_s = ST_EPD3;
                end else begin
                    next_state_s = ST_EPD2;
                end
            end
            ST_EPD3: begin
                if (xmit_change_s) begin
                    next_state_s = ST_TX_TEST_XMIT;
                end else if (bus.TX_OSET_indicate) begin
                    next_state_s = ST_XMIT_DATA;
                end else begin
                    next_state_s = ST_EPD3;
                end
            end
            default: next_state_s = ST_TX_TEST_XMIT;
        endcase
    end

    // State register. The Moore outputs are registered from the next state, so they change on the same edge as the state.
    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state_r        <= ST_TX_TEST_XMIT;
            xmit_latched_r <= XMIT_IDLE;
            transmitting_r <= 1'b0;
            col_r          <= 1'b0;
            tx_o_set_r     <= OS_I;
            tx_data_r      <= 8'h00;
        end else begin
            state_r        <= next_state_s;
            if (state_r == ST_TX_TEST_XMIT) begin
                xmit_latched_r <= xmit_norm_s;
            end else begin
                xmit_latched_r <= xmit_latched_r;
            end
            transmitting_r <= (next_state_s == ST_START_OF_PACKET) ||
                              (next_state_s == ST_TX_PACKET);
            col_r          <= transmitting_r & bus.receiving;
            tx_o_set_r     <= oset_of(next_state_s);
            tx_data_r      <= bus.TXD;
        end
    end

    assign bus.transmitting = transmitting_r;
    assign bus.COL          = col_r;
    assign bus.tx_o_set     = tx_o_set_r;
    assign bus.tx_data      = tx_data_r;

endmodule

// File: tb/tb_transmit_os.sv
// Directed-vector bench for transmit_os. A scoreboard queue holds the hand-computed
// outputs for each cycle, and a negedge monitor compares them with the DUT.
module tb_transmit_os;

    localparam logic [2:0] D = 3'd0;
    localparam logic [2:0] I = 3'd1;
    localparam logic [2:0] C = 3'd2;
    localparam logic [2:0] S = 3'd3;
    localparam logic [2:0] T = 3'd4;
    localparam logic [2:0] R = 3'd5;

    typedef struct {
        logic [2:0] os;
        logic       tr;
        logic       col;
        logic [7:0] data;
        int         idx;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    tests = 0;
    int    failed = 0;
    int    step_n = 0;
    exp_t  exp_q[$];

    transmit_os_if bus ();

    transmit_os dut (
        .GTX_CLK       (clk),
        .mr_main_reset (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Monitor: the DUT drives its outputs every cycle, so each negedge uses one expected entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tx_o_set",     e.idx, {5'd0, bus.tx_o_set},     {5'd0, e.os});
            chk("transmitting", e.idx, {7'd0, bus.transmitting}, {7'd0, e.tr});
            chk("COL",          e.idx, {7'd0, bus.COL},          {7'd0, e.col});
            chk("tx_data",      e.idx, bus.tx_data,              e.data);
        end
    end

    task automatic step(input logic r, input logic [2:0] x, input logic en, input logic [7:0] d,
                        input logic rv, input logic os, input logic ev,
                        input logic [2:0] e_os, input logic e_tr, input logic e_col, input logic [7:0] e_d);
        exp_t e;
        rst                  = r;
        bus.xmit             = x;
        bus.TX_EN            = en;
        bus.TXD              = d;
        bus.receiving        = rv;
        bus.TX_OSET_indicate = os;
        bus.tx_even          = ev;
        @(posedge clk);
        step_n++;
        e.os = e_os; e.tr = e_tr; e.col = e_col; e.data = e_d; e.idx = step_n;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Columns: rst xmit TX_EN TXD receiving OSET tx_even | expected o_set transmitting COL tx_data
        step(1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 1 reset
        step(1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  C, 1'b0, 1'b0, 8'h00); // 2 to CONFIGURATION
        step(1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  C, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0,  C, 1'b0, 1'b0, 8'hAA); // 4 no OSET, hold
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 5 TX_TEST_XMIT
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 6 XMIT_DATA
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  I, 1'b0, 1'b0, 8'h00);
        // packet A with collision, tx_even=0 at EPD2
        step(1'b0, 3'd2, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0,  S, 1'b1, 1'b0, 8'h01); // 8
        step(1'b0, 3'd2, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1,  D, 1'b1, 1'b1, 8'h02);
        step(1'b0, 3'd2, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0,  D, 1'b1, 1'b1, 8'h03);
        step(1'b0, 3'd2, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1,  D, 1'b1, 1'b1, 8'h04);
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0,  T, 1'b0, 1'b1, 8'h00); // 12
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1,  R, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0,  R, 1'b0, 1'b0, 8'h00); // 14 EPD3
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,  I, 1'b0, 1'b0, 8'h00);
        // packet B with a stall in TX_PACKET, tx_even=1 at EPD2
        step(1'b0, 3'd2, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0,  S, 1'b1, 1'b0, 8'h11); // 16
        step(1'b0, 3'd2, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1,  D, 1'b1, 1'b0, 8'h22);
        step(1'b0, 3'd2, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0,  D, 1'b1, 1'b0, 8'h33);
        step(1'b0, 3'd2, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1,  D, 1'b1, 1'b0, 8'h33);
        step(1'b0, 3'd2, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0,  D, 1'b1, 1'b0, 8'h33);
        step(1'b0, 3'd2, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1,  D, 1'b1, 1'b0, 8'h44); // 21
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  T, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  R, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1,  I, 1'b0, 1'b0, 8'h00); // 24
        // reset mid-packet, then TX_EN high at TX_TEST_XMIT
        step(1'b0, 3'd2, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0,  S, 1'b1, 1'b0, 8'h55);
        step(1'b0, 3'd2, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1,  D, 1'b1, 1'b0, 8'h66);
        step(1'b1, 3'd2, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 27
        step(1'b0, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 28 IDLE
        step(1'b0, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 30 XMIT_DATA
        // mode change from XMIT_DATA, unknown xmit codes
        step(1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 32
        step(1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  C, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 34
        step(1'b0, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  C, 1'b0, 1'b0, 8'h00); // 38
        // xmit change inside a packet takes effect only after the packet
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd2, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0,  S, 1'b1, 1'b0, 8'h01); // 41
        step(1'b0, 3'd4, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0,  D, 1'b1, 1'b0, 8'h02);
        step(1'b0, 3'd4, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0,  D, 1'b1, 1'b0, 8'h03);
        step(1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  T, 1'b0, 1'b0, 8'h00);
        step(1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00); // 45
        step(1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0,  I, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
